// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states
// and the nibble-index width helper.
// Optional feature macro: NSA_OVERFLOW_EN (adds the ovf output).
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the nibble index: clog2(nib), never less than one bit.
    function automatic int unsigned idx_width(input int unsigned nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// Optional feature macro: NSA_OVERFLOW_EN (adds the ovf signal).
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;
`ifdef NSA_OVERFLOW_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, busy, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, busy
    );
`endif
endinterface

// File: rtl/nibble_serial_adder_cla_nibble.sv
// Purely combinational 4-bit carry-lookahead slice. c3 is the carry into
// bit 3, exposed so the top can derive signed overflow on the MSB nibble.
module cla_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s = p ^ {c3, c2, c1, cin};
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit CLA slice: one nibble per
// cycle, carry held in a register, result returned over valid/ready.
// Optional feature macro: NSA_OVERFLOW_EN (registered two's-complement ovf).
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t               state;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     sum_reg;
    logic                 carry_reg;
    logic [IDX_W-1:0]     idx;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic                 c_out_r;

    logic [NIBBLE_W-1:0]  slice_a;
    logic [NIBBLE_W-1:0]  slice_b;
    logic [NIBBLE_W-1:0]  slice_s;
    logic                 slice_cout;
    logic                 slice_c3;

    assign slice_a = a_reg[NIBBLE_W*idx +: NIBBLE_W];
    assign slice_b = b_reg[NIBBLE_W*idx +: NIBBLE_W];

    cla_nibble u_cla (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

`ifdef NSA_OVERFLOW_EN
    logic ovf_r;

    // Overflow captured on the last RUN cycle from the MSB slice carries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (state == ST_IDLE && bus.in_valid) begin
            ovf_r <= 1'b0;
        end else if (state == ST_RUN && idx == IDX_LAST) begin
            ovf_r <= slice_c3 ^ slice_cout;
        end
    end

    assign bus.ovf = ovf_r;
`else
    logic unused_c3;
    assign unused_c3 = slice_c3;
`endif

    // Sequencer: accept operands, step one nibble per cycle, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            carry_reg   <= 1'b0;
            idx         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            c_out_r     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.a;
                        b_reg      <= bus.b;
                        carry_reg  <= bus.c_in;
                        idx        <= '0;
                        sum_reg    <= '0;
                        c_out_r    <= 1'b0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_reg[NIBBLE_W*idx +: NIBBLE_W] <= slice_s;
                    carry_reg <= slice_cout;
                    if (idx == IDX_LAST) begin
                        c_out_r     <= slice_cout;
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.sum       = sum_reg;
    assign bus.c_out     = c_out_r;

endmodule
